// File: rtl/pipeline_controller_pkg.sv
// Shared types for the pipeline stall/flush controller.
package pipeline_controller_pkg;

   localparam int unsigned RegIdxW = 5;
   localparam logic [RegIdxW-1:0] RegX0 = '0;

   typedef enum logic [1:0] {
      StRun,
      StMemWait,
      StMuldivBusy
   } ctrl_state_t;

   typedef struct packed {
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic stall_mem;
      logic flush_id;
      logic flush_ex;
      logic bubble_mem;
      logic muldiv_start;
      logic mem_fault;
   } ctrl_out_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// Hazard/handshake events from ID/EX/MEM and the per-stage hold/clear strobes.
interface pipeline_controller_if;

   logic [pipeline_controller_pkg::RegIdxW-1:0] id_rs1;
   logic [pipeline_controller_pkg::RegIdxW-1:0] id_rs2;
   logic                                        id_uses_rs1;
   logic                                        id_uses_rs2;
   logic [pipeline_controller_pkg::RegIdxW-1:0] ex_rd;
   logic                                        ex_is_load;
   logic                                        ex_is_muldiv;
   logic                                        branch_taken;
   logic                                        muldiv_done;
   logic                                        mem_req;
   logic                                        mem_ack;

   logic stall_if;
   logic stall_id;
   logic stall_ex;
   logic stall_mem;
   logic flush_id;
   logic flush_ex;
   logic bubble_mem;
   logic muldiv_start;
   logic mem_fault;

   // Pipeline side: raises events, consumes strobes.
   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load, ex_is_muldiv,
             branch_taken, muldiv_done, mem_req, mem_ack,
      input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_mem,
             muldiv_start, mem_fault
   );

   // Controller side.
   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load, ex_is_muldiv,
             branch_taken, muldiv_done, mem_req, mem_ack,
      output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_mem,
             muldiv_start, mem_fault
   );

endinterface

// File: rtl/pipeline_controller_load_use_detect.sv
// Combinational load-use hazard compare between the ID sources and the EX load target.
module load_use_detect
   import pipeline_controller_pkg::*;
(
   input  logic [RegIdxW-1:0] id_rs1_i,
   input  logic [RegIdxW-1:0] id_rs2_i,
   input  logic               id_uses_rs1_i,
   input  logic               id_uses_rs2_i,
   input  logic [RegIdxW-1:0] ex_rd_i,
   input  logic               ex_is_load_i,
   output logic               hazard_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit  = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit  = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
   // x0 is hardwired zero, so a load into it never creates a dependency.
   assign hazard_o = ex_is_load_i && (ex_rd_i != RegX0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_controller.sv
// Central stall/flush sequencer for the five-stage core.
// Optional load-use bubble enabled by defining LOAD_USE_STALL_EN.
module pipeline_controller
   import pipeline_controller_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   pipeline_controller_if.slave        ctrl_io
);

   localparam int unsigned CntW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam bit TimeoutEn = (MEM_TIMEOUT != 0);
   localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

   ctrl_state_t     state_q, state_d;
   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   ctrl_out_t       out;
   logic            mem_hold;
   logic            load_use;
   logic            run_eval;

   assign mem_hold = ctrl_io.mem_req && !ctrl_io.mem_ack;

`ifdef LOAD_USE_STALL_EN
   load_use_detect u_load_use_detect (
      .id_rs1_i      (ctrl_io.id_rs1),
      .id_rs2_i      (ctrl_io.id_rs2),
      .id_uses_rs1_i (ctrl_io.id_uses_rs1),
      .id_uses_rs2_i (ctrl_io.id_uses_rs2),
      .ex_rd_i       (ctrl_io.ex_rd),
      .ex_is_load_i  (ctrl_io.ex_is_load),
      .hazard_o      (load_use)
   );
`else
   logic unused_lu_inputs;
   assign unused_lu_inputs = ^{ctrl_io.id_rs1, ctrl_io.id_rs2, ctrl_io.id_uses_rs1,
                               ctrl_io.id_uses_rs2, ctrl_io.ex_rd, ctrl_io.ex_is_load};
   assign load_use = 1'b0;
`endif

   always_comb begin
      out        = '0;
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      run_eval   = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StRun: run_eval = 1'b1;
            StMemWait: begin
               if (ctrl_io.mem_ack) begin
                  run_eval = 1'b1;
               end else if (TimeoutEn && (wait_cnt_q == TimeoutVal)) begin
                  out.mem_fault = 1'b1;
                  state_d       = StRun;
                  wait_cnt_d    = '0;
               end else begin
                  out.stall_if  = 1'b1;
                  out.stall_id  = 1'b1;
                  out.stall_ex  = 1'b1;
                  out.stall_mem = 1'b1;
                  wait_cnt_d    = wait_cnt_q + CntW'(1);
               end
            end
            StMuldivBusy: begin
               // MEM holds a bubble here, so mem_req is deliberately not looked at.
               if (ctrl_io.muldiv_done) begin
                  state_d = StRun;
               end else begin
                  out.stall_if   = 1'b1;
                  out.stall_id   = 1'b1;
                  out.stall_ex   = 1'b1;
                  out.bubble_mem = 1'b1;
               end
            end
            default: state_d = StRun;
         endcase

         if (run_eval) begin
            state_d    = StRun;
            wait_cnt_d = '0;
            if (mem_hold) begin
               out.stall_if  = 1'b1;
               out.stall_id  = 1'b1;
               out.stall_ex  = 1'b1;
               out.stall_mem = 1'b1;
               state_d       = StMemWait;
               wait_cnt_d    = CntW'(1);
            end else if (ctrl_io.ex_is_muldiv) begin
               out.stall_if     = 1'b1;
               out.stall_id     = 1'b1;
               out.stall_ex     = 1'b1;
               out.bubble_mem   = 1'b1;
               out.muldiv_start = 1'b1;
               state_d          = StMuldivBusy;
            end else if (ctrl_io.branch_taken) begin
               out.flush_id = 1'b1;
               out.flush_ex = 1'b1;
            end else if (load_use) begin
               out.stall_if = 1'b1;
               out.stall_id = 1'b1;
               out.flush_ex = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign ctrl_io.stall_if     = out.stall_if;
   assign ctrl_io.stall_id     = out.stall_id;
   assign ctrl_io.stall_ex     = out.stall_ex;
   assign ctrl_io.stall_mem    = out.stall_mem;
   assign ctrl_io.flush_id     = out.flush_id;
   assign ctrl_io.flush_ex     = out.flush_ex;
   assign ctrl_io.bubble_mem   = out.bubble_mem;
   assign ctrl_io.muldiv_start = out.muldiv_start;
   assign ctrl_io.mem_fault    = out.mem_fault;

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the five-stage core. It takes hazard and handshake events from the ID, EX and MEM stages and produces per-stage hold and clear strobes. Events handled: data-memory wait states with timeout, multi-cycle mul/div occupancy, taken-branch flush and an optional load-use bubble. It sits beside the operand-forwarding logic and guarantees that forwarded operands are valid when EX consumes them.

## Interface
- MEM_TIMEOUT, default 16: maximum consecutive memory-wait stall cycles; 0 disables the timeout.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads rs1 / rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_is_load  in  1  the EX instruction is a load
- ex_is_muldiv  in  1  the EX instruction is a mul/div
- branch_taken  in  1  taken branch or jump resolved in EX
- muldiv_done  in  1  mul/div result valid, single-cycle pulse
- mem_req, mem_ack  in  1 each  data-memory access in MEM / access complete
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM register
- flush_id, flush_ex, bubble_mem  out  1 each  clear IF-ID / ID-EX / EX-MEM to a NOP on the next edge
- muldiv_start  out  1  one-cycle start strobe to the mul/div unit
- mem_fault  out  1  one-cycle pulse when a memory-wait timeout fires

## Operation
- States: RUN, MEM_WAIT, MULDIV_BUSY. A wait_cnt register has width $clog2(MEM_TIMEOUT+1), minimum 1.
- Outputs are combinational from state, wait_cnt and the inputs. While rst is high, all outputs are 0, state is RUN and wait_cnt is 0.
- mem_hold = mem_req && !mem_ack.
- RUN, events in priority order:
  - mem_hold: all four stalls = 1; next state MEM_WAIT; wait_cnt <= 1.
  - ex_is_muldiv: stall_if/id/ex = 1, bubble_mem = 1, muldiv_start = 1; next state MULDIV_BUSY.
  - branch_taken: flush_id = 1 and flush_ex = 1. A branch always overrides the load-use bubble.
  - load-use (only when the macro is enabled): stall_if = 1, stall_id = 1, flush_ex = 1.
  - A load-use event requires ex_is_load, ex_rd != 0, and (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd).
- MEM_WAIT:
  - If mem_ack: no memory stall this cycle; the remaining RUN priority list (muldiv, branch, load-use) is evaluated in the same cycle; next state follows RUN rules, otherwise RUN.
  - Else if MEM_TIMEOUT != 0 and wait_cnt == MEM_TIMEOUT: no stall, mem_fault = 1; next state RUN.
  - Else: all four stalls = 1; wait_cnt increments.
- MULDIV_BUSY:
  - stall_if/id/ex = 1 and bubble_mem = 1 until muldiv_done.
  - In the muldiv_done cycle, all outputs are 0 and the next state is RUN. Branch and load-use are not evaluated in this cycle.
  - mem_req is ignored in this state, because MEM holds a bubble.
- muldiv_done outside MULDIV_BUSY is ignored.
- branch_taken during any stall is ignored. EX is frozen, so the signal re-presents when the stall releases.

## Timing
- Zero-latency control: strobes are valid in the same cycle as the causing event and act at the next rising edge.
- A memory access with N wait cycles (N < MEM_TIMEOUT) produces exactly N cycles of full stall.
- A timeout produces exactly MEM_TIMEOUT stall cycles followed by one mem_fault cycle.
- A mul/div of latency L (done asserted L cycles after start, L ≥ 1) stalls IF/ID/EX for L cycles, counting the start cycle and excluding the done cycle.
- muldiv_start is high for exactly one cycle per mul/div instruction.
- Asserting rst mid-sequence returns to RUN immediately; no mem_fault is emitted.

## Configuration
- LOAD_USE_STALL_EN defined: a load-use hazard inserts one bubble (stall_if/id for 1 cycle plus flush_ex).
- LOAD_USE_STALL_EN undefined: no load-use detection. The dependent instruction proceeds and the forwarding logic selects memory read data combinationally.

## Structure
- The shared core package holds the ctrl_state_t enum (RUN, MEM_WAIT, MULDIV_BUSY) and the x0 register-index constant.
- One sub-module, load_use_detect, is purely combinational. It contains the register-compare logic and is instantiated only under LOAD_USE_STALL_EN.

## Test plan
- Memory wait: mem_req with mem_ack after 3 cycles -> stall_* high for exactly 3 cycles, no mem_fault, state back to RUN.
- Memory timeout: MEM_TIMEOUT=4, mem_ack never asserted -> 4 stall cycles, then mem_fault for one cycle, then stalls low.
- Mul/div: ex_is_muldiv with done after 5 cycles -> muldiv_start for 1 cycle, stall_if/id/ex and bubble_mem for 5 cycles, then all low.
- Load-use with the macro enabled: ex_is_load, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of stall_if/id and flush_ex.
  - Same stimulus with ex_rd=0 -> no stall.
  - Same stimulus with the macro disabled -> no stall.
- Simultaneous events:
  - branch_taken with a load-use hazard -> flush_id/flush_ex only.
  - mem_req stall with branch_taken -> stalls only; flush occurs in the ack cycle.
- Reset while in MULDIV_BUSY -> outputs 0 immediately; a later muldiv_done is ignored.
